comm_ctrl: RTL and testbench

//  Parametrised UART command controller, successor to the byte-prompted comm block. Decodes host

---
 rtl/comm_pkg.sv | 25 ++
 rtl/comm_rx_hold.sv | 35 +++
 rtl/comm_ctrl.sv | 164 ++++++++++++++++
 tb/tb_comm_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// comm_pkg: command/response byte codes and controller state encoding for comm_ctrl.
// COMM_CHECKSUM_EN appends an XOR checksum byte before 'E' on r/w transfers.
package comm_pkg;
    localparam logic [7:0] CMD_PING  = 8'h70;  // 'p'
    localparam logic [7:0] CMD_EXEC  = 8'h78;  // 'x'
    localparam logic [7:0] CMD_STAT  = 8'h73;  // 's'
    localparam logic [7:0] CMD_READ  = 8'h72;  // 'r'
    localparam logic [7:0] CMD_WRITE = 8'h77;  // 'w'
    localparam logic [7:0] RSP_PING  = 8'h50;  // 'P'
    localparam logic [7:0] RSP_EXEC  = 8'h58;  // 'X'
    localparam logic [7:0] RSP_READ  = 8'h52;  // 'R'
    localparam logic [7:0] RSP_WRITE = 8'h57;  // 'W'
    localparam logic [7:0] RSP_ACK   = 8'h2B;  // '+'
    localparam logic [7:0] RSP_NAK   = 8'h2D;  // '-'
    localparam logic [7:0] RSP_UNK   = 8'h3F;  // '?'
    localparam logic [7:0] RSP_END   = 8'h45;  // 'E'
`ifdef COMM_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif
    typedef enum logic [2:0] {
        ST_IDLE, ST_RD_REQ, ST_RD_WAIT, ST_RD_SEND, ST_WR, ST_WR_MEM, ST_CSUM, ST_END
    } state_e;
endpackage

// File: rtl/comm_rx_hold.sv
// comm_rx_hold: single-byte receive holding register with sticky overrun flag.
module comm_rx_hold (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    input  logic       pop_i,
    input  logic       clr_ovr_i,
    output logic       full_o,
    output logic [7:0] data_o,
    output logic       overrun_o
);
    logic       full_q;
    logic [7:0] data_q;
    logic       ovr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            if (rx_valid_i && !full_q) begin
                full_q <= 1'b1;
                data_q <= rx_data_i;
            end else if (pop_i) begin
                full_q <= 1'b0;
            end
            // a byte arriving while full is lost even if the hold is popped this cycle
            ovr_q <= (rx_valid_i && full_q) || (ovr_q && !clr_ovr_i);
        end
    end
    assign full_o    = full_q;
    assign data_o    = data_q;
    assign overrun_o = ovr_q;
endmodule

// File: rtl/comm_ctrl.sv
// comm_ctrl: UART command controller (ping/exec/status/memory read & write streaming).
// Optional COMM_CHECKSUM_EN: XOR checksum byte precedes 'E' on r/w transfers.
module comm_ctrl
    import comm_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int MEM_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              exec_start,
    input  logic              cpu_running,
    output logic              rx_overrun
);
    localparam int BPW = DATA_W / 8;
    localparam int BCW = $clog2(BPW) + 1;
    state_e              state_q;
    logic                tx_valid_q, mem_req_q, mem_we_q, exec_q;
    logic [7:0]          tx_data_q, csum_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q, word_q, shifted;
    logic [ADDR_W:0]     word_cnt_q;
    logic [BCW-1:0]      byte_cnt_q;
    logic                hold_full, take, last_word, last_byte;
    logic [7:0]          hold_data;
    state_e              after_last;
    // a byte is only consumed when its response can be loaded immediately
    assign take       = hold_full && !tx_valid_q && (state_q == ST_IDLE || state_q == ST_WR);
    assign last_word  = word_cnt_q == (ADDR_W+1)'(MEM_WORDS - 1);
    assign last_byte  = byte_cnt_q == BCW'(BPW - 1);
    assign shifted    = DATA_W'({word_q, hold_data});
    assign after_last = CSUM_EN ? ST_CSUM : ST_END;
    comm_rx_hold u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid_i(rx_valid),
        .rx_data_i (rx_data),
        .pop_i     (take),
        .clr_ovr_i (take && state_q == ST_IDLE && hold_data == CMD_PING),
        .full_o    (hold_full),
        .data_o    (hold_data),
        .overrun_o (rx_overrun)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            exec_q      <= 1'b0;
            word_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            csum_q      <= '0;
        end else begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            exec_q      <= 1'b0;
            if (tx_valid_q && tx_ready) tx_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (take) begin
                    tx_valid_q <= 1'b1;
                    word_cnt_q <= '0;
                    byte_cnt_q <= '0;
                    csum_q     <= '0;
                    case (hold_data)
                        CMD_PING: tx_data_q <= RSP_PING;
                        CMD_EXEC: begin
                            tx_data_q <= RSP_EXEC;
                            exec_q    <= 1'b1;
                        end
                        CMD_STAT: tx_data_q <= cpu_running ? RSP_ACK : RSP_NAK;
                        CMD_READ: begin
                            tx_data_q <= RSP_READ;
                            mem_req_q <= 1'b1;
                            state_q   <= ST_RD_REQ;
                        end
                        CMD_WRITE: begin
                            tx_data_q <= RSP_WRITE;
                            state_q   <= ST_WR;
                        end
                        default: tx_data_q <= RSP_UNK;
                    endcase
                end
                ST_RD_REQ: state_q <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    word_q  <= mem_rdata;
                    state_q <= ST_RD_SEND;
                end
                ST_RD_SEND: if (!tx_valid_q) begin
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= word_q[DATA_W-1 -: 8];
                    csum_q     <= csum_q ^ word_q[DATA_W-1 -: 8];
                    word_q     <= word_q << 8;
                    byte_cnt_q <= last_byte ? '0 : byte_cnt_q + 1'b1;
                    if (last_byte && last_word) begin
                        state_q <= after_last;
                    end else if (last_byte) begin
                        word_cnt_q <= word_cnt_q + 1'b1;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= ADDR_W'(word_cnt_q + 1'b1);
                        state_q    <= ST_RD_REQ;
                    end
                end
                ST_WR: if (take) begin
                    word_q <= shifted;
                    csum_q <= csum_q ^ hold_data;
                    if (last_byte) begin
                        byte_cnt_q  <= '0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= word_cnt_q[ADDR_W-1:0];
                        mem_wdata_q <= shifted;
                        state_q     <= ST_WR_MEM;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + 1'b1;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= RSP_ACK;
                    end
                end
                ST_WR_MEM: begin
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= RSP_NAK;
                    word_cnt_q <= word_cnt_q + 1'b1;
                    state_q    <= last_word ? after_last : ST_WR;
                end
                ST_CSUM: if (!tx_valid_q) begin
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= csum_q;
                    state_q    <= ST_END;
                end
                ST_END: if (!tx_valid_q) begin
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= RSP_END;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
    assign tx_valid   = tx_valid_q;
    assign tx_data    = tx_data_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign exec_start = exec_q;
endmodule

// File: tb/tb_comm_ctrl.sv
// tb_comm_ctrl: randomized scoreboard bench for comm_ctrl; expected TX bytes come from a
// byte-level command model, a monitor pops and compares on every TX handshake.
module tb_comm_ctrl;
    localparam int DATA_W = 16, ADDR_W = 16, MEM_WORDS = 4, BPW = DATA_W / 8;
    logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, tx_ready = 1'b0, cpu_running = 1'b0;
    logic [7:0] rx_data = '0, tx_data;
    logic tx_valid, mem_req, mem_we, exec_start, rx_overrun;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata = '0;
    logic [DATA_W-1:0] ram [MEM_WORDS];
    logic [DATA_W-1:0] ref_mem [MEM_WORDS];
    logic [7:0] exp_q [$];
    int checks = 0, errors = 0, exec_seen = 0, exec_exp = 0, tx_cnt = 0;
    bit exp_ovr = 1'b0, stall = 1'b0;

    comm_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .exec_start(exec_start), .cpu_running(cpu_running),
        .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req && mem_we) ram[int'(mem_addr) % MEM_WORDS] <= mem_wdata;
        if (mem_req && !mem_we) mem_rdata <= ram[int'(mem_addr) % MEM_WORDS];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1 tx_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    initial begin
        logic pend;
        logic [7:0] pdata;
        pend = 1'b0;
        pdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) check("tx_hold", {tx_valid, tx_data}, {1'b1, pdata});
                if (tx_valid && tx_ready) begin
                    tx_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_extra: got %0h, expected no byte", tx_data);
                    end else begin
                        check("tx_byte", tx_data, exp_q.pop_front());
                    end
                end
                if (!mem_req) check("mem_idle", {mem_we, mem_addr, mem_wdata}, 0);
                else check("mem_addr_range", mem_addr < MEM_WORDS, 1);
                if (exec_start) exec_seen++;
                pend = tx_valid && !tx_ready;
                pdata = tx_data;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk);
        #1 rx_valid = 1'b1;
        rx_data = b;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (4) @(posedge clk);
    endtask

    task automatic model_cmd(input logic [7:0] c);
        logic [7:0] x, bt;
        case (c)
            "p": begin exp_q.push_back("P"); exp_ovr = 1'b0; end
            "x": begin exp_q.push_back("X"); exec_exp++; end
            "s": exp_q.push_back(cpu_running ? "+" : "-");
            "w": exp_q.push_back("W");
            "r": begin
                exp_q.push_back("R");
                x = '0;
                for (int i = 0; i < MEM_WORDS; i++)
                    for (int b = 0; b < BPW; b++) begin
                        bt = 8'(ref_mem[i] >> (8 * (BPW - 1 - b)));
                        x ^= bt;
                        exp_q.push_back(bt);
                    end
`ifdef COMM_CHECKSUM_EN
                exp_q.push_back(x);
`endif
                exp_q.push_back("E");
            end
            default: exp_q.push_back("?");
        endcase
    endtask

    task automatic cmd(input logic [7:0] c);
        model_cmd(c);
        send_rx(c);
        drain("cmd");
    endtask

    task automatic status(input string name);
        check({name, "_exec_count"}, exec_seen, exec_exp);
        check({name, "_overrun"}, rx_overrun, exp_ovr);
    endtask

    task automatic do_write(input logic [DATA_W-1:0] w0, w1, w2, w3);
        logic [DATA_W-1:0] wv [MEM_WORDS];
        logic [7:0] x, bt;
        wv = '{w0, w1, w2, w3};
        cmd("w");
        x = '0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            for (int b = 0; b < BPW; b++) begin
                bt = 8'(wv[i] >> (8 * (BPW - 1 - b)));
                x ^= bt;
                exp_q.push_back(b == BPW - 1 ? "-" : "+");
                if (i == MEM_WORDS - 1 && b == BPW - 1) begin
`ifdef COMM_CHECKSUM_EN
                    exp_q.push_back(x);
`endif
                    exp_q.push_back("E");
                end
                send_rx(bt);
                drain("wr_byte");
            end
            ref_mem[i] = wv[i];
        end
        for (int i = 0; i < MEM_WORDS; i++) check("ram_word", ram[i], ref_mem[i]);
    endtask

    initial begin
        int base, n, r;
        logic [7:0] c;
        for (int i = 0; i < MEM_WORDS; i++) begin ram[i] = '0; ref_mem[i] = '0; end
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", {tx_valid, tx_data, mem_req, mem_we, mem_addr, mem_wdata,
                                   exec_start, rx_overrun}, 0);
        rst_n = 1'b1;
        cmd("p");
        status("ping");
        ram = '{16'h1234, 16'hABCD, 16'h0000, 16'hFFFF};
        ref_mem = '{16'h1234, 16'hABCD, 16'h0000, 16'hFFFF};
        cmd("r");
        do_write(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        cpu_running = 1'b0;
        cmd("s");
        cpu_running = 1'b1;
        cmd("s");
        cmd("x");
        status("exec");
        // overflow the hold while the transmitter is stalled: third byte is lost
        stall = 1'b1;
        model_cmd("s");
        send_rx("s");
        model_cmd("x");
        send_rx("x");
        send_rx("s");
        exp_ovr = 1'b1;
        repeat (50) @(posedge clk);
        #1 check("stall_overrun", rx_overrun, 1);
        check("stall_tx_pending", tx_valid, 1);
        stall = 1'b0;
        drain("overrun");
        status("overrun");
        cmd("p");
        status("overrun_clear");
        // reset in the middle of a read stream
        model_cmd("r");
        base = tx_cnt;
        send_rx("r");
        n = 0;
        while (tx_cnt < base + 3 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("rst_wait_bytes", tx_cnt >= base + 3, 1);
        #2 rst_n = 1'b0;
        #1 check("midread_reset_outputs", {tx_valid, tx_data, mem_req, mem_we, mem_addr,
                                           mem_wdata, exec_start, rx_overrun}, 0);
        exp_q.delete();
        exp_ovr = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        cmd("p");
        status("after_reset");
        for (int k = 0; k < 60; k++) begin
            cpu_running = 1'($urandom);
            r = $urandom_range(0, 9);
            if (r < 2) cmd("p");
            else if (r == 2) cmd("x");
            else if (r == 3) cmd("s");
            else if (r < 6) cmd("r");
            else if (r < 8) do_write(DATA_W'($urandom), DATA_W'($urandom),
                                     DATA_W'($urandom), DATA_W'($urandom));
            else begin
                c = 8'($urandom);
                if (c == "p" || c == "x" || c == "s" || c == "r" || c == "w") c = 8'h00;
                cmd(c);
            end
            status("random");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
